// File: rtl/cap_frame_ctrl.sv
// Frame-level capture sequencer in the PCLK domain: aligns CAPON to whole VSYNC frames,
// drops the rest of a frame on FIFO overflow and raises TOUT when VSYNC stops toggling.
module cap_frame_ctrl #(
  parameter int                TOUT_W  = 24,
  parameter logic [TOUT_W-1:0] TIMEOUT = 24'd12_000_000,
  parameter int                CNT_W   = 16
) (
  input  logic             PCLK,
  input  logic             PRST,
  input  logic             CAPENB,
  input  logic             CONT,
  input  logic             CLRERR,
  input  logic             VSYNC,
  input  logic             FIFOFULL,
  input  logic             FIFOWR,
  output logic             CAPON,
  output logic             BUSY,
  output logic             FRMDONE,
  output logic [CNT_W-1:0] FRMCNT,
  output logic             OVF,
  output logic             TOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_FALL,
    S_CAPT,
    S_SKIP
  } state_t;

  localparam logic [TOUT_W-1:0] WD_LAST = TIMEOUT - TOUT_W'(1);

  state_t             state_q, state_d;
  logic               vs_q, vs_qq;
  logic               cont_q, cont_d;
  logic [CNT_W-1:0]   frmcnt_q, frmcnt_d;
  logic [TOUT_W-1:0]  wd_q, wd_d;
  logic               capon_q, capon_d;
  logic               busy_q, busy_d;
  logic               frmdone_q, frmdone_d;
  logic               ovf_q, ovf_d;
  logic               tout_q, tout_d;
  logic               vs_rise, vs_fall;
  logic               wd_expire;
  logic               ovf_set, tout_set;

  assign vs_rise   = vs_q & ~vs_qq;
  assign vs_fall   = ~vs_q & vs_qq;
  assign wd_expire = (state_q != S_IDLE) && (wd_q == WD_LAST);

  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      state_q   <= S_IDLE;
      vs_q      <= 1'b0;
      vs_qq     <= 1'b0;
      cont_q    <= 1'b0;
      frmcnt_q  <= '0;
      wd_q      <= '0;
      capon_q   <= 1'b0;
      busy_q    <= 1'b0;
      frmdone_q <= 1'b0;
      ovf_q     <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_q      <= VSYNC;
      vs_qq     <= vs_q;
      cont_q    <= cont_d;
      frmcnt_q  <= frmcnt_d;
      wd_q      <= wd_d;
      capon_q   <= capon_d;
      busy_q    <= busy_d;
      frmdone_q <= frmdone_d;
      ovf_q     <= ovf_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    frmcnt_d  = frmcnt_q;
    capon_d   = 1'b0;
    frmdone_d = 1'b0;
    ovf_set   = 1'b0;
    tout_set  = 1'b0;

    // Watchdog only runs while a capture is pending; any VSYNC edge proves the camera is alive.
    if ((state_q == S_IDLE) || vs_rise || vs_fall) begin
      wd_d = '0;
    end else if (wd_q != '1) begin
      wd_d = wd_q + TOUT_W'(1);
    end else begin
      wd_d = wd_q;
    end

    case (state_q)
      S_IDLE: begin
        if (CAPENB) begin
          state_d  = S_ARM;
          cont_d   = CONT;
          frmcnt_d = '0;
        end
      end
      S_ARM: begin
        // Waiting for a vertical blank start keeps capture from beginning mid-frame.
        if (!CAPENB) begin
          state_d = S_IDLE;
        end else if (vs_rise) begin
          state_d = S_WAIT_FALL;
        end
      end
      S_WAIT_FALL: begin
        if (vs_fall) begin
          state_d = S_CAPT;
          capon_d = 1'b1;
        end
      end
      S_CAPT: begin
        capon_d = 1'b1;
        // Overflow takes precedence over a coincident frame end: the frame is lost.
        if (FIFOWR && FIFOFULL) begin
          ovf_set = 1'b1;
          capon_d = 1'b0;
          state_d = S_SKIP;
        end else if (vs_rise) begin
          frmdone_d = 1'b1;
          frmcnt_d  = frmcnt_q + CNT_W'(1);
          capon_d   = 1'b0;
          state_d   = (cont_q && CAPENB) ? S_WAIT_FALL : S_IDLE;
        end
      end
      S_SKIP: begin
        if (vs_rise) begin
          state_d = (cont_q && CAPENB) ? S_WAIT_FALL : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (wd_expire) begin
      tout_set  = 1'b1;
      capon_d   = 1'b0;
      frmdone_d = 1'b0;
      frmcnt_d  = frmcnt_q;
      state_d   = S_IDLE;
    end

    // Sticky flags: a set in the same cycle as CLRERR survives.
    ovf_d  = ovf_set | (ovf_q & ~CLRERR);
    tout_d = tout_set | (tout_q & ~CLRERR);
    busy_d = (state_d != S_IDLE);
  end

  assign CAPON   = capon_q;
  assign BUSY    = busy_q;
  assign FRMDONE = frmdone_q;
  assign FRMCNT  = frmcnt_q;
  assign OVF     = ovf_q;
  assign TOUT    = tout_q;

endmodule

// File: tb/tb_cap_frame_ctrl.sv
// Directed bench for cap_frame_ctrl: frames of 100 VSYNC-high cycles plus 700 active
// cycles, watchdog shortened to 1000 cycles so it fits inside the run.
module tb_cap_frame_ctrl;

  localparam int CNT_W   = 16;
  localparam int VS_LEN  = 100;
  localparam int ACT_LEN = 700;

  logic             PCLK = 1'b0;
  logic             PRST;
  logic             CAPENB, CONT, CLRERR, VSYNC, FIFOFULL, FIFOWR;
  logic             CAPON, BUSY, FRMDONE, OVF, TOUT;
  logic [CNT_W-1:0] FRMCNT;

  int   total = 0;
  int   bad   = 0;
  int   cyc, on_cnt, done_cnt, rise_at, fall_at;
  logic capon_prev = 1'b0;

  cap_frame_ctrl #(
    .TOUT_W (24),
    .TIMEOUT(24'd1000),
    .CNT_W  (CNT_W)
  ) dut (
    .PCLK    (PCLK),
    .PRST    (PRST),
    .CAPENB  (CAPENB),
    .CONT    (CONT),
    .CLRERR  (CLRERR),
    .VSYNC   (VSYNC),
    .FIFOFULL(FIFOFULL),
    .FIFOWR  (FIFOWR),
    .CAPON   (CAPON),
    .BUSY    (BUSY),
    .FRMDONE (FRMDONE),
    .FRMCNT  (FRMCNT),
    .OVF     (OVF),
    .TOUT    (TOUT)
  );

  // clock/reset block
  always #5 PCLK = ~PCLK;

  initial begin
    #3_000_000;
    $display("FAIL run_time_limit: got no end of run, want end before 3 ms");
    $fatal(1, "time limit");
  end

  // driver tasks: one step = one rising edge, then inputs change and outputs are sampled 1 ns later
  task automatic step();
    @(posedge PCLK);
    #1;
    cyc++;
    if (CAPON === 1'b1) on_cnt++;
    if (FRMDONE === 1'b1) done_cnt++;
    if (CAPON === 1'b1 && capon_prev !== 1'b1) rise_at = cyc;
    capon_prev = CAPON;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_mon();
    cyc = 0; on_cnt = 0; done_cnt = 0; rise_at = -1;
  endtask

  // VSYNC high for the blanking period, then low; the fall is driven as the task returns.
  task automatic vs_pulse();
    VSYNC = 1'b1;
    steps(VS_LEN);
    VSYNC = 1'b0;
  endtask

  task automatic test_reset();
    PRST = 1'b1; CAPENB = 1'b0; CONT = 1'b0; CLRERR = 1'b0;
    VSYNC = 1'b0; FIFOFULL = 1'b0; FIFOWR = 1'b0;
    #12;
    total++; if (CAPON !== 1'b0) begin bad++; $display("FAIL reset_capon: got %b want 0", CAPON); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    total++; if (FRMDONE !== 1'b0) begin bad++; $display("FAIL reset_frmdone: got %b want 0", FRMDONE); end
    total++; if (FRMCNT !== 16'd0) begin bad++; $display("FAIL reset_frmcnt: got %0d want 0", FRMCNT); end
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    total++; if (TOUT !== 1'b0) begin bad++; $display("FAIL reset_tout: got %b want 0", TOUT); end
    @(negedge PCLK);
    PRST = 1'b0;
    steps(2);
  endtask

  task automatic test_single();
    clr_mon();
    CONT = 1'b0; CAPENB = 1'b1;
    step();
    vs_pulse();
    fall_at = cyc;
    steps(300);
    CAPENB = 1'b0;
    steps(ACT_LEN - 300);
    vs_pulse();
    steps(50);
    // pin falls in the cycle after fall_at; CAPON is high two edges later (third cycle)
    total++; if (rise_at !== fall_at + 2) begin bad++; $display("FAIL single_capon_start: got %0d want %0d", rise_at, fall_at + 2); end
    total++; if (on_cnt !== ACT_LEN) begin bad++; $display("FAIL single_capon_len: got %0d want %0d", on_cnt, ACT_LEN); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_frmdone: got %0d want 1", done_cnt); end
    total++; if (FRMCNT !== 16'd1) begin bad++; $display("FAIL single_frmcnt: got %0d want 1", FRMCNT); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", BUSY); end
    total++; if (CAPON !== 1'b0) begin bad++; $display("FAIL single_capon_end: got %b want 0", CAPON); end
  endtask

  task automatic test_continuous();
    clr_mon();
    CONT = 1'b1; CAPENB = 1'b1;
    step();
    total++; if (FRMCNT !== 16'd0) begin bad++; $display("FAIL cont_frmcnt_clear: got %0d want 0", FRMCNT); end
    for (int f = 0; f < 4; f++) begin
      vs_pulse();
      if (f == 2) begin
        steps(350);
        CAPENB = 1'b0;
        steps(ACT_LEN - 350);
      end else begin
        steps(ACT_LEN);
      end
    end
    steps(20);
    total++; if (done_cnt !== 3) begin bad++; $display("FAIL cont_frmdone: got %0d want 3", done_cnt); end
    total++; if (FRMCNT !== 16'd3) begin bad++; $display("FAIL cont_frmcnt: got %0d want 3", FRMCNT); end
    total++; if (on_cnt !== 3 * ACT_LEN) begin bad++; $display("FAIL cont_capon_len: got %0d want %0d", on_cnt, 3 * ACT_LEN); end
    total++; if (CAPON !== 1'b0) begin bad++; $display("FAIL cont_capon_end: got %b want 0", CAPON); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL cont_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_midframe();
    clr_mon();
    CONT = 1'b0; CAPENB = 1'b1;
    steps(300);
    total++; if (on_cnt !== 0) begin bad++; $display("FAIL mid_no_capon_active: got %0d want 0", on_cnt); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy_armed: got %b want 1", BUSY); end
    vs_pulse();
    total++; if (on_cnt !== 0) begin bad++; $display("FAIL mid_no_capon_blank: got %0d want 0", on_cnt); end
    fall_at = cyc;
    steps(200);
    CAPENB = 1'b0;
    steps(ACT_LEN - 200);
    vs_pulse();
    steps(10);
    total++; if (rise_at !== fall_at + 2) begin bad++; $display("FAIL mid_capon_start: got %0d want %0d", rise_at, fall_at + 2); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL mid_frmdone: got %0d want 1", done_cnt); end
    total++; if (FRMCNT !== 16'd1) begin bad++; $display("FAIL mid_frmcnt: got %0d want 1", FRMCNT); end
  endtask

  task automatic test_watchdog();
    clr_mon();
    CONT = 1'b0; CAPENB = 1'b1; VSYNC = 1'b0;
    steps(1000);
    total++; if (TOUT !== 1'b0) begin bad++; $display("FAIL wd_early: got %b want 0", TOUT); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL wd_busy_before: got %b want 1", BUSY); end
    step();
    total++; if (TOUT !== 1'b1) begin bad++; $display("FAIL wd_tout: got %b want 1", TOUT); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL wd_idle: got %b want 0", BUSY); end
    total++; if (CAPON !== 1'b0) begin bad++; $display("FAIL wd_capon: got %b want 0", CAPON); end
    CAPENB = 1'b0;
    steps(5);
    total++; if (TOUT !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", TOUT); end
    CLRERR = 1'b1;
    step();
    CLRERR = 1'b0;
    total++; if (TOUT !== 1'b0) begin bad++; $display("FAIL wd_clrerr: got %b want 0", TOUT); end
  endtask

  task automatic test_overflow();
    clr_mon();
    CONT = 1'b1; CAPENB = 1'b1;
    step();
    vs_pulse();
    steps(500);
    FIFOWR = 1'b1; FIFOFULL = 1'b1;
    step();
    FIFOWR = 1'b0; FIFOFULL = 1'b0;
    total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", OVF); end
    total++; if (CAPON !== 1'b0) begin bad++; $display("FAIL ovf_capon_off: got %b want 0", CAPON); end
    steps(ACT_LEN - 501);
    total++; if (on_cnt !== 499) begin bad++; $display("FAIL ovf_capon_len: got %0d want 499", on_cnt); end
    vs_pulse();
    steps(300);
    CAPENB = 1'b0;
    steps(ACT_LEN - 300);
    vs_pulse();
    steps(10);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ovf_frmdone: got %0d want 1", done_cnt); end
    total++; if (FRMCNT !== 16'd1) begin bad++; $display("FAIL ovf_frmcnt: got %0d want 1", FRMCNT); end
    total++; if (on_cnt !== 499 + ACT_LEN) begin bad++; $display("FAIL ovf_frame2_len: got %0d want %0d", on_cnt, 499 + ACT_LEN); end
    total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", OVF); end
    CLRERR = 1'b1;
    step();
    CLRERR = 1'b0;
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL ovf_clrerr: got %b want 0", OVF); end
    CAPENB = 1'b1;
    step();
    vs_pulse();
    steps(50);
    FIFOWR = 1'b1; FIFOFULL = 1'b1; CLRERR = 1'b1;
    step();
    FIFOWR = 1'b0; FIFOFULL = 1'b0; CLRERR = 1'b0;
    total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovf_set_beats_clr: got %b want 1", OVF); end
    CAPENB = 1'b0;
    vs_pulse();
    steps(10);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL ovf_skip_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_async_reset();
    clr_mon();
    CONT = 1'b1; CAPENB = 1'b1;
    step();
    vs_pulse();
    steps(ACT_LEN);
    vs_pulse();
    steps(100);
    total++; if (CAPON !== 1'b1) begin bad++; $display("FAIL arst_pre_capon: got %b want 1", CAPON); end
    total++; if (FRMCNT !== 16'd1) begin bad++; $display("FAIL arst_pre_frmcnt: got %0d want 1", FRMCNT); end
    total++; if (OVF !== 1'b1) begin bad++; $display("FAIL arst_pre_ovf: got %b want 1", OVF); end
    #2;
    PRST = 1'b1;
    #1;
    total++; if (CAPON !== 1'b0) begin bad++; $display("FAIL arst_capon: got %b want 0", CAPON); end
    total++; if (FRMCNT !== 16'd0) begin bad++; $display("FAIL arst_frmcnt: got %0d want 0", FRMCNT); end
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL arst_ovf: got %b want 0", OVF); end
    total++; if (TOUT !== 1'b0) begin bad++; $display("FAIL arst_tout: got %b want 0", TOUT); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", BUSY); end
    CAPENB = 1'b0;
    #20;
    PRST = 1'b0;
    clr_mon();
    steps(20);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL arst_no_frmdone: got %0d want 0", done_cnt); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL arst_idle_after: got %b want 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_midframe();
    test_watchdog();
    test_overflow();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
